// File: rtl/ysyx_25040111_axi_bridge.sv
// AXI4 master bridge: turns one LSU load/store/line-fill request into AXI4 channel
// traffic, one transaction at a time, returning per-beat load data and a done pulse.
module ysyx_25040111_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_wen,
  input  logic              req_ren,
  input  logic [1:0]        req_mask,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_tlen,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_beat,
  output logic              rsp_done,
  output logic              rsp_err,
  output logic              busy,
  input  logic              io_master_awready,
  output logic              io_master_awvalid,
  output logic [ADDR_W-1:0] io_master_awaddr,
  output logic [3:0]        io_master_awid,
  output logic [7:0]        io_master_awlen,
  output logic [2:0]        io_master_awsize,
  output logic [1:0]        io_master_awburst,
  input  logic              io_master_wready,
  output logic              io_master_wvalid,
  output logic [DATA_W-1:0] io_master_wdata,
  output logic [3:0]        io_master_wstrb,
  output logic              io_master_wlast,
  output logic              io_master_bready,
  input  logic              io_master_bvalid,
  input  logic [1:0]        io_master_bresp,
  input  logic [3:0]        io_master_bid,
  input  logic              io_master_arready,
  output logic              io_master_arvalid,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [3:0]        io_master_arid,
  output logic [7:0]        io_master_arlen,
  output logic [2:0]        io_master_arsize,
  output logic [1:0]        io_master_arburst,
  output logic              io_master_rready,
  input  logic              io_master_rvalid,
  input  logic [1:0]        io_master_rresp,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic              io_master_rlast,
  input  logic [3:0]        io_master_rid
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_W, S_B} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_mask;
  logic              r_sign;
  logic [7:0]        r_tlen;
  logic [7:0]        r_cnt;
  logic              r_aw_ok;
  logic              r_w_ok;
  logic              r_err_acc;
  logic              r_beat;
  logic              r_done;
  logic              r_err;

  logic              w_busy;
  logic              w_accept;
  logic              w_r_hs;
  logic              w_r_last;
  logic              w_r_bad;
  logic [1:0]        w_size;
  logic [3:0]        w_strb_base;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_rdata_fmt;
  logic [DATA_W-1:0] w_wdata_rep;
  logic              w_unused;

  // Busy covers the rsp_done cycle too, so a request arriving then is dropped.
  assign w_busy   = (r_state != S_IDLE) || r_done;
  assign w_accept = (r_state == S_IDLE) && req_valid && !w_busy;
  assign w_r_hs   = (r_state == S_R) && io_master_rvalid;
  assign w_r_last = io_master_rlast || (r_cnt == r_tlen);
  assign w_r_bad  = (io_master_rresp != 2'b00);
  assign w_unused = ^{io_master_bid, io_master_rid};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) begin
        if (req_wen)      w_next = S_W;
        else if (req_ren) w_next = S_AR;
      end
      S_AR:    if (io_master_arready) w_next = S_R;
      S_R:     if (w_r_hs && w_r_last) w_next = S_IDLE;
      S_W:     if ((r_aw_ok || io_master_awready) && (r_w_ok || io_master_wready)) w_next = S_B;
      S_B:     if (io_master_bvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_wvalid  = 1'b0;
    io_master_bready  = 1'b0;
    unique case (r_state)
      S_AR:    io_master_arvalid = 1'b1;
      S_R:     io_master_rready  = 1'b1;
      S_W: begin
        io_master_awvalid = !r_aw_ok;
        io_master_wvalid  = !r_w_ok;
      end
      S_B:     io_master_bready  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_size      = 2'd2;
    w_strb_base = 4'b1111;
    w_wdata_rep = r_wdata;
    unique case (r_mask)
      2'b01: begin
        w_size      = 2'd0;
        w_strb_base = 4'b0001;
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b10: begin
        w_size      = 2'd1;
        w_strb_base = 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Single-beat loads are lane-aligned and extended; bursts are raw line data.
  always_comb begin
    w_shifted = io_master_rdata >> {r_addr[1:0], 3'b000};
    unique case (r_mask)
      2'b01:   w_rdata_fmt = {{(DATA_W-8){r_sign & w_shifted[7]}}, w_shifted[7:0]};
      2'b10:   w_rdata_fmt = {{(DATA_W-16){r_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_rdata_fmt = w_shifted;
    endcase
    if (r_tlen != 8'd0) w_rdata_fmt = io_master_rdata;
  end

  assign io_master_awaddr  = r_addr;
  assign io_master_awid    = 4'd0;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = {1'b0, w_size};
  assign io_master_awburst = 2'b01;
  assign io_master_wdata   = w_wdata_rep;
  assign io_master_wstrb   = w_strb_base << r_addr[1:0];
  assign io_master_wlast   = 1'b1;
  assign io_master_araddr  = r_addr;
  assign io_master_arid    = 4'd0;
  assign io_master_arlen   = r_tlen;
  assign io_master_arsize  = {1'b0, w_size};
  assign io_master_arburst = 2'b01;

  // NOTE: request fields are pure datapath, qualified by the FSM, so they need no reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_addr  <= req_addr;
      r_mask  <= req_mask;
      r_sign  <= req_sign;
      r_wdata <= req_wdata;
      r_tlen  <= req_tlen;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= 8'd0;
      r_aw_ok   <= 1'b0;
      r_w_ok    <= 1'b0;
      r_err_acc <= 1'b0;
      r_rdata   <= '0;
      r_beat    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_beat <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt     <= 8'd0;
          r_aw_ok   <= 1'b0;
          r_w_ok    <= 1'b0;
          r_err_acc <= 1'b0;
          if (!req_wen && !req_ren) r_done <= 1'b1;
        end
        S_R: if (w_r_hs) begin
          r_rdata   <= w_rdata_fmt;
          r_beat    <= 1'b1;
          r_cnt     <= r_cnt + 8'd1;
          r_err_acc <= r_err_acc || w_r_bad;
          if (w_r_last) begin
            r_done <= 1'b1;
            r_err  <= r_err_acc || w_r_bad;
          end
        end
        S_W: begin
          if (io_master_awready) r_aw_ok <= 1'b1;
          if (io_master_wready)  r_w_ok  <= 1'b1;
        end
        S_B: if (io_master_bvalid) begin
          r_done <= 1'b1;
          r_err  <= (io_master_bresp != 2'b00);
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_beat  = r_beat;
  assign rsp_done  = r_done;
  assign rsp_err   = r_err;
  assign busy      = w_busy;

endmodule
